// File: rtl/te_ctrl_pkg.sv
// Shared control definitions for the tracking-engine channel scheduler and fill latch:
// scheduler state encoding, round word counts and per-channel state word indices.
package te_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        SCAN  = 4'd1,
        FILL  = 4'd2,
        TAIL  = 4'd3,
        START = 4'd4,
        WAIT  = 4'd5,
        DUMP  = 4'd6,
        NEXT  = 4'd7,
        DONE  = 4'd8
    } sched_state_e;

    // Per-channel state word indices; words 0..5 are configuration, 6..15 evolve per block.
    localparam logic [4:0] CARRIER_FREQ  = 5'd0;
    localparam logic [4:0] CODE_FREQ     = 5'd1;
    localparam logic [4:0] PRN1_CONFIG   = 5'd2;
    localparam logic [4:0] PRN2_CONFIG   = 5'd3;
    localparam logic [4:0] CODE_DELAY    = 5'd4;
    localparam logic [4:0] CORR_CONFIG   = 5'd5;
    localparam logic [4:0] CARRIER_PHASE = 5'd6;
    localparam logic [4:0] CODE_PHASE    = 5'd7;
    localparam logic [4:0] CARRIER_COUNT = 5'd8;
    localparam logic [4:0] CODE_COUNT    = 5'd9;
    localparam logic [4:0] CORR_I_ACC    = 5'd10;
    localparam logic [4:0] CORR_Q_ACC    = 5'd11;
    localparam logic [4:0] DUMP_COUNT    = 5'd12;
    localparam logic [4:0] BIT_SYNC      = 5'd13;
    localparam logic [4:0] PRN1_STATE    = 5'd14;
    localparam logic [4:0] PRN2_STATE    = 5'd15;

    localparam int         FILL_WORDS = 16;
    localparam logic [4:0] DUMP_FIRST = CARRIER_PHASE;
    localparam logic [4:0] DUMP_LAST  = PRN2_STATE;

endpackage

// File: rtl/te_channel_sched_if.sv
// State RAM / fill latch / correlator side of the channel scheduler.
// Handshake: corr_start is a one-cycle request pulse; corr_done is a one-cycle completion
// pulse from the correlator and is only acted on while the scheduler is waiting for it.
interface te_channel_sched_if #(
    parameter int CH_W = 5
);
    logic            fill_enable;
    logic            state_rd;
    logic            state_wr;
    logic [4:0]      state_addr;
    logic [CH_W-1:0] channel_index;
    logic [CH_W+4:0] state_ram_addr;
    logic            corr_start;
    logic            corr_done;

    modport master (
        output fill_enable, state_rd, state_wr, state_addr,
               channel_index, state_ram_addr, corr_start,
        input  corr_done
    );

    modport slave (
        input  fill_enable, state_rd, state_wr, state_addr,
               channel_index, state_ram_addr, corr_start,
        output corr_done
    );
endinterface

// File: rtl/te_channel_sched.sv
// Round scheduler: walks enabled channels in ascending order, filling state, running the
// correlator and writing back the variable state words, once per sample-block round.
module te_channel_sched
    import te_ctrl_pkg::*;
#(
    parameter int CH_NUM = 32,
    parameter int CH_W   = 5
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                round_start,
    input  logic                sw_abort,
    input  logic [CH_NUM-1:0]   channel_enable,
    output logic                busy,
    output logic                round_done,
    output logic                round_overrun,
    output sched_state_e        state_dbg,
    te_channel_sched_if.master  bus
);

    sched_state_e        state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [4:0]          word_q, word_d;
    logic [CH_NUM-1:0]   mask_q, mask_d;

    logic                fill_q, rd_q, wr_q, cs_q, busy_q, done_q, ovr_q;
    logic [4:0]          addr_q;
    logic [CH_W-1:0]     idx_q;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CH_NUM - 1);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            ch_q    <= '0;
            word_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        word_d  = word_q;
        mask_d  = mask_q;
        // Abort leaves ch and word where they were; the next round clears ch anyway.
        if (sw_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (round_start) begin
                        mask_d  = channel_enable;
                        ch_d    = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (mask_q[ch_q]) begin
                        word_d  = CARRIER_FREQ;
                        state_d = FILL;
                    end else if (ch_q == LAST_CH) begin
                        state_d = DONE;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
                FILL: begin
                    if (word_q == 5'(FILL_WORDS - 1)) state_d = TAIL;
                    else                              word_d  = word_q + 5'd1;
                end
                TAIL:  state_d = START;
                START: state_d = WAIT;
                WAIT: begin
                    if (bus.corr_done) begin
                        word_d  = DUMP_FIRST;
                        state_d = DUMP;
                    end
                end
                DUMP: begin
                    if (word_q == DUMP_LAST) state_d = NEXT;
                    else                     word_d  = word_q + 5'd1;
                end
                NEXT: begin
                    if (ch_q == LAST_CH) begin
                        state_d = DONE;
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = SCAN;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            fill_q <= 1'b0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            cs_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
            addr_q <= '0;
            idx_q  <= '0;
        end else begin
            fill_q <= (state_d == FILL) || (state_d == TAIL);
            rd_q   <= (state_d == FILL);
            wr_q   <= (state_d == DUMP);
            cs_q   <= (state_d == START);
            busy_q <= (state_d != IDLE);
            done_q <= (state_d == DONE);
            ovr_q  <= round_start && (state_q != IDLE);
            addr_q <= word_d;
            idx_q  <= ch_d;
        end
    end

    assign busy               = busy_q;
    assign round_done         = done_q;
    assign round_overrun      = ovr_q;
    assign state_dbg          = state_q;
    assign bus.fill_enable    = fill_q;
    assign bus.state_rd       = rd_q;
    assign bus.state_wr       = wr_q;
    assign bus.corr_start     = cs_q;
    assign bus.state_addr     = addr_q;
    assign bus.channel_index  = idx_q;
    assign bus.state_ram_addr = {idx_q, addr_q};

endmodule

// File: tb/tb_te_channel_sched.sv
// Bench for te_channel_sched: per-round timelines are computed arithmetically from the
// channel mask and correlator delays, then compared cycle by cycle against the outputs.
module tb_te_channel_sched;
    import te_ctrl_pkg::*;

    localparam int CH_NUM = 32;
    localparam int CH_W   = 5;
    localparam int MAXC   = 2000;

    // clock / reset
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic              round_start = 1'b0;
    logic              sw_abort = 1'b0;
    logic [CH_NUM-1:0] channel_enable = '0;
    logic              busy, round_done, round_overrun;
    sched_state_e      state_dbg;

    te_channel_sched_if #(.CH_W(CH_W)) bus();

    te_channel_sched #(.CH_NUM(CH_NUM), .CH_W(CH_W)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .round_start    (round_start),
        .sw_abort       (sw_abort),
        .channel_enable (channel_enable),
        .busy           (busy),
        .round_done     (round_done),
        .round_overrun  (round_overrun),
        .state_dbg      (state_dbg),
        .bus            (bus.master)
    );

    // expected timeline and stimulus tables
    bit          e_fill[MAXC], e_rd[MAXC], e_wr[MAXC], e_cs[MAXC];
    bit          e_busy[MAXC], e_done[MAXC], e_ovr[MAXC];
    int          e_ch[MAXC], e_wd[MAXC];
    bit          s_rs[MAXC], s_ab[MAXC], s_cd[MAXC];
    logic [31:0] s_en[MAXC];
    int          dly[CH_NUM];
    int          first_rd[CH_NUM], start_cyc[CH_NUM], first_dump[CH_NUM];

    logic [26:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [26:0] raw_obs();
        return {bus.fill_enable, bus.state_rd, bus.state_wr, bus.corr_start,
                busy, round_done, round_overrun,
                bus.channel_index, bus.state_addr, bus.state_ram_addr};
    endfunction

    function automatic logic [26:0] masked_obs();
        logic [26:0] v;
        v = raw_obs();
        if (!(bus.state_rd || bus.state_wr)) v[19:0] = '0;
        return v;
    endfunction

    task automatic clear_scn();
        for (int c = 0; c < MAXC; c++) begin
            e_fill[c] = 0; e_rd[c] = 0; e_wr[c] = 0; e_cs[c] = 0;
            e_busy[c] = 0; e_done[c] = 0; e_ovr[c] = 0;
            e_ch[c] = 0; e_wd[c] = 0;
            s_rs[c] = 0; s_ab[c] = 0; s_cd[c] = 0;
            s_en[c] = $urandom;
        end
        for (int ch = 0; ch < CH_NUM; ch++) dly[ch] = $urandom_range(8, 1);
    endtask

    // Reference model: a round is 1 scan cycle per channel, plus 29+d more for enabled ones.
    task automatic plan_round(input int t0, input logic [31:0] mask, output int t_done);
        int t;
        s_rs[t0] = 1;
        s_en[t0] = mask;
        t = t0 + 1;
        for (int ch = 0; ch < CH_NUM; ch++) begin
            if (mask[ch]) begin
                first_rd[ch] = t + 1;
                for (int i = 0; i < 16; i++) begin
                    e_rd[t+1+i] = 1; e_fill[t+1+i] = 1; e_ch[t+1+i] = ch; e_wd[t+1+i] = i;
                end
                e_fill[t+17] = 1;
                e_cs[t+18] = 1;
                start_cyc[ch] = t + 18;
                s_cd[t+18+dly[ch]] = 1;
                first_dump[ch] = t + 19 + dly[ch];
                for (int j = 0; j < 10; j++) begin
                    e_wr[first_dump[ch]+j] = 1; e_ch[first_dump[ch]+j] = ch;
                    e_wd[first_dump[ch]+j] = 6 + j;
                end
                t = t + 30 + dly[ch];
            end else begin
                t = t + 1;
            end
        end
        e_done[t] = 1;
        for (int c = t0 + 1; c <= t; c++) e_busy[c] = 1;
        t_done = t;
    endtask

    task automatic abort_at(input int a, input int t_done);
        s_ab[a] = 1;
        for (int c = a + 1; c <= t_done; c++) begin
            e_fill[c] = 0; e_rd[c] = 0; e_wr[c] = 0; e_cs[c] = 0;
            e_busy[c] = 0; e_done[c] = 0; s_cd[c] = 0;
        end
    endtask

    task automatic overrun_at(input int c);
        s_rs[c] = 1;
        e_ovr[c+1] = 1;
    endtask

    // driver + scoreboard: one packed comparison per cycle
    task automatic run_scn(input string name, input int len);
        logic [26:0] ev;
        logic [4:0]  ec, ew;
        for (int k = 0; k < len; k++) begin
            ec = 5'(e_ch[k]);
            ew = 5'(e_wd[k]);
            ev = {e_fill[k], e_rd[k], e_wr[k], e_cs[k], e_busy[k], e_done[k], e_ovr[k], 20'd0};
            if (e_rd[k] || e_wr[k]) ev[19:0] = {ec, ew, ec, ew};
            exp_q.push_back(ev);
        end
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            round_start    = s_rs[k];
            sw_abort       = s_ab[k];
            bus.corr_done  = s_cd[k];
            channel_enable = s_en[k];
            @(negedge clk);
            chk($sformatf("%s_cyc%0d", name, k), 32'(masked_obs()), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
        round_start = 0; sw_abort = 0; bus.corr_done = 0;
    endtask

    initial begin
        int td, td2, a, lim, n_ov;
        logic [31:0] m;
        bus.corr_done = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 32'(raw_obs()), 32'd0);
        chk("reset_state", 32'(state_dbg), 32'(IDLE));
        rst_b = 1'b1;

        // single channel 0, corr_done 4 cycles after corr_start
        clear_scn();
        dly[0] = 4;
        plan_round(2, 32'h0000_0001, td);
        run_scn("ch0", td + 4);

        // channels 0, 2, 31
        clear_scn();
        plan_round(2, 32'h8000_0005, td);
        run_scn("ch0_2_31", td + 4);

        // abort+start together in IDLE, then empty mask round
        clear_scn();
        s_rs[2] = 1; s_ab[2] = 1; s_en[2] = 32'hffff_ffff;
        plan_round(5, 32'h0, td);
        run_scn("mask0", td + 4);

        // overrun during WAIT and during DONE
        clear_scn();
        dly[4] = 6;
        plan_round(2, 32'h0001_0010, td);
        overrun_at(start_cyc[4] + 2);
        overrun_at(td);
        run_scn("overrun", td + 4);

        // abort at dump word 9 of channel 1, then a fresh round starting at channel 0
        clear_scn();
        dly[1] = 3;
        plan_round(2, 32'h0000_0002, td);
        abort_at(first_dump[1] + 3, td);
        plan_round(td + 5, 32'h0000_0001, td2);
        run_scn("abort", td2 + 4);

        // spurious corr_done in FILL and START, long wait
        clear_scn();
        dly[3] = 40;
        plan_round(2, 32'h0000_0008, td);
        s_cd[first_rd[3] + 3]  = 1;
        s_cd[first_rd[3] + 10] = 1;
        s_cd[start_cyc[3]]     = 1;
        run_scn("spurious", td + 4);

        // randomized rounds with random overruns and occasional aborts
        for (int r = 0; r < 12; r++) begin
            clear_scn();
            m = $urandom & $urandom & $urandom;
            plan_round(2, m, td);
            lim = td;
            if ($urandom_range(3, 0) == 0) begin
                a = $urandom_range(td, 3);
                abort_at(a, td);
                lim = a;
            end
            n_ov = $urandom_range(2, 0);
            for (int i = 0; i < n_ov; i++) overrun_at($urandom_range(lim, 3));
            run_scn($sformatf("rnd%0d", r), td + 4);
        end

        // asynchronous reset in the middle of a fill
        @(posedge clk);
        #1;
        round_start = 1; channel_enable = 32'h1;
        @(posedge clk);
        #1;
        round_start = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("mid_fill_rd", 32'(bus.state_rd), 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("async_rst_outs", 32'(raw_obs()), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("post_rst_state", 32'(state_dbg), 32'(IDLE));
        chk("post_rst_outs", 32'(raw_obs()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
